// File: rtl/dvi_tx_link_seq.sv
// dvi_tx_link_seq: pixel-clock link sequencer feeding a 4-lane TMDS serializer.
// Chooses control tokens or encoder words per lane, drives the clock pattern on
// lane 3, and starts/stops the link only on frame boundaries.
// Optional statistics (frame counter, DE-at-vsync error flag) are built when the
// macro DVI_TX_LINK_STATS_EN is defined.
module dvi_tx_link_seq #(
   parameter int         HOLD_CYCLES = 1024,
   parameter logic       VS_POL      = 1'b1,
   parameter logic [9:0] CLK_PATTERN = 10'b1111100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_en,
   input  logic        de_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [9:0]  enc_0_in,
   input  logic [9:0]  enc_1_in,
   input  logic [9:0]  enc_2_in,
   output logic [9:0]  tmds_0,
   output logic [9:0]  tmds_1,
   output logic [9:0]  tmds_2,
   output logic [9:0]  tmds_3,
   output logic        link_active,
`ifdef DVI_TX_LINK_STATS_EN
   output logic [15:0] frame_cnt,
   output logic [0:0]  de_err,
`endif
   output logic        frame_start
);

   localparam logic [9:0] TOK00 = 10'b1101010100;
   localparam logic [9:0] TOK01 = 10'b0010101011;
   localparam logic [9:0] TOK10 = 10'b0101010100;
   localparam logic [9:0] TOK11 = 10'b1010101011;

   // Counter only has to reach HOLD_CYCLES-1; keep at least one bit when the hold is skipped.
   localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_HOLD  = 3'd1,
      ST_SYNC  = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          vs_prev_q;
   logic [9:0]    tmds_0_q, tmds_0_d;
   logic [9:0]    tmds_1_q, tmds_1_d;
   logic [9:0]    tmds_2_q, tmds_2_d;
   logic [9:0]    tmds_3_q;
   logic          link_active_q, link_active_d;
   logic          frame_start_q, frame_start_d;
   logic          vs_rise;
   logic          video;

   function automatic logic [9:0] tok(input logic [1:0] c);
      case (c)
         2'b00:   tok = TOK00;
         2'b01:   tok = TOK01;
         2'b10:   tok = TOK10;
         default: tok = TOK11;
      endcase
   endfunction

   assign vs_rise = (vsync_in == VS_POL) && (vs_prev_q != VS_POL);

   // Next state and hold counter; disable always wins over frame events.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         ST_OFF: begin
            if (tx_en) state_d = (HOLD_CYCLES == 0) ? ST_SYNC : ST_HOLD;
         end
         ST_HOLD: begin
            cnt_d = cnt_q + CW'(1);
            if (!tx_en)                  state_d = ST_OFF;
            else if (cnt_q == HOLD_LAST) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (!tx_en)       state_d = ST_OFF;
            else if (vs_rise) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!tx_en) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // A new frame is never started while draining, even if tx_en came back.
            if (vs_rise)    state_d = ST_OFF;
            else if (tx_en) state_d = ST_RUN;
         end
         default: state_d = ST_OFF;
      endcase
   end

   // Lane word selection: video rules while transmitting, tokens otherwise.
   always_comb begin
      video = ((state_q == ST_RUN) || (state_q == ST_DRAIN) ||
               ((state_q == ST_SYNC) && vs_rise && tx_en)) &&
              !((state_q == ST_DRAIN) && vs_rise);
      tmds_0_d = tok({vsync_in, hsync_in});
      tmds_1_d = TOK00;
      tmds_2_d = TOK00;
      if (video && de_in) begin
         tmds_0_d = enc_0_in;
         tmds_1_d = enc_1_in;
         tmds_2_d = enc_2_in;
      end
      frame_start_d = video && vs_rise;
      link_active_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
   end

   // State, history and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_OFF;
         cnt_q         <= '0;
         vs_prev_q     <= ~VS_POL;
         tmds_0_q      <= TOK00;
         tmds_1_q      <= TOK00;
         tmds_2_q      <= TOK00;
         tmds_3_q      <= CLK_PATTERN;
         link_active_q <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         vs_prev_q     <= vsync_in;
         tmds_0_q      <= tmds_0_d;
         tmds_1_q      <= tmds_1_d;
         tmds_2_q      <= tmds_2_d;
         tmds_3_q      <= CLK_PATTERN;
         link_active_q <= link_active_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign tmds_0      = tmds_0_q;
   assign tmds_1      = tmds_1_q;
   assign tmds_2      = tmds_2_q;
   assign tmds_3      = tmds_3_q;
   assign link_active = link_active_q;
   assign frame_start = frame_start_q;

`ifdef DVI_TX_LINK_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        de_err_q, de_err_d;

   // Transmitted-frame counter (wrapping) and sticky DE-at-frame-start flag.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      de_err_d    = de_err_q;
      if (frame_start_d)          frame_cnt_d = frame_cnt_q + 16'd1;
      if (video && vs_rise && de_in) de_err_d = 1'b1;
   end

   // Statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= 16'd0;
         de_err_q    <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         de_err_q    <= de_err_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign de_err    = de_err_q;
`endif

endmodule

// File: tb/tb_dvi_tx_link_seq.sv
// Directed bench for dvi_tx_link_seq with HOLD_CYCLES=4.
// Build with DVI_TX_LINK_STATS_EN defined to also cover the statistics outputs.
module tb_dvi_tx_link_seq;

   localparam logic [9:0] T00 = 10'b1101010100;
   localparam logic [9:0] T01 = 10'b0010101011;
   localparam logic [9:0] T10 = 10'b0101010100;
   localparam logic [9:0] T11 = 10'b1010101011;
   localparam logic [9:0] CLKP = 10'b1111100000;

   logic       clk = 1'b0;
   logic       rst, tx_en, de_in, hsync_in, vsync_in;
   logic [9:0] enc_0_in, enc_1_in, enc_2_in;
   logic [9:0] tmds_0, tmds_1, tmds_2, tmds_3;
   logic       link_active, frame_start;
`ifdef DVI_TX_LINK_STATS_EN
   logic [15:0] frame_cnt;
   logic [0:0]  de_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dvi_tx_link_seq #(.HOLD_CYCLES(4), .VS_POL(1'b1), .CLK_PATTERN(10'b1111100000)) dut (
      .clk(clk), .rst(rst), .tx_en(tx_en), .de_in(de_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .enc_0_in(enc_0_in), .enc_1_in(enc_1_in), .enc_2_in(enc_2_in),
      .tmds_0(tmds_0), .tmds_1(tmds_1), .tmds_2(tmds_2), .tmds_3(tmds_3),
      .link_active(link_active),
`ifdef DVI_TX_LINK_STATS_EN
      .frame_cnt(frame_cnt), .de_err(de_err),
`endif
      .frame_start(frame_start)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one input cycle, then sample its registered result just after the edge.
   task automatic cyc(input logic en, input logic de, input logic hs, input logic vs,
                      input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
      tx_en = en; de_in = de; hsync_in = hs; vsync_in = vs;
      enc_0_in = e0; enc_1_in = e1; enc_2_in = e2;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [9:0] t0, input logic [9:0] t1,
                          input logic [9:0] t2, input logic la, input logic fs);
      chk({tag, ".t0"}, {6'd0, tmds_0}, {6'd0, t0});
      chk({tag, ".t1"}, {6'd0, tmds_1}, {6'd0, t1});
      chk({tag, ".t2"}, {6'd0, tmds_2}, {6'd0, t2});
      chk({tag, ".t3"}, {6'd0, tmds_3}, {6'd0, CLKP});
      chk({tag, ".la"}, {15'd0, link_active}, {15'd0, la});
      chk({tag, ".fs"}, {15'd0, frame_start}, {15'd0, fs});
      $display("step %-12s t0=%h t1=%h t2=%h t3=%h la=%b fs=%b",
               tag, tmds_0, tmds_1, tmds_2, tmds_3, link_active, frame_start);
   endtask

   initial begin
      rst = 1'b1;
      cyc(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      cyc(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      chk_out("reset", T00, T00, T00, 0, 0);
`ifdef DVI_TX_LINK_STATS_EN
      chk("reset.fcnt", frame_cnt, 16'd0);
      chk("reset.derr", {15'd0, de_err}, 16'd0);
`endif
      rst = 1'b0;

      // Link off: tokens only, de ignored, vsync toggling has no effect
      cyc(0, 0, 1, 1, 10'h0, 10'h0, 10'h0);
      chk_out("off_vs", T11, T00, T00, 0, 0);
      cyc(0, 1, 0, 0, 10'h155, 10'h2AB, 10'h0F0);
      chk_out("off_de", T00, T00, T00, 0, 0);

      // Enable: OFF->HOLD, four hold cycles, vsync rise inside hold ignored
      cyc(1, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      chk_out("en", T00, T00, T00, 0, 0);
      cyc(1, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      cyc(1, 0, 0, 1, 10'h0, 10'h0, 10'h0);
      chk_out("hold_vs", T10, T00, T00, 0, 0);
      cyc(1, 0, 0, 1, 10'h0, 10'h0, 10'h0);
      cyc(1, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      cyc(1, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      chk_out("sync_wait", T00, T00, T00, 0, 0);

      // Frame start in SYNC
      cyc(1, 0, 0, 1, 10'h0, 10'h0, 10'h0);
      chk_out("run_start", T10, T00, T00, 1, 1);
      cyc(1, 1, 0, 1, 10'h155, 10'h2AB, 10'h0F0);
      chk_out("run_de", 10'h155, 10'h2AB, 10'h0F0, 1, 0);
      cyc(1, 0, 1, 0, 10'h3FF, 10'h3FF, 10'h3FF);
      chk_out("run_hs", T01, T00, T00, 1, 0);

      // Disable mid-frame, then return while draining
      cyc(0, 1, 0, 0, 10'h3C3, 10'h111, 10'h222);
      chk_out("drain_in", 10'h3C3, 10'h111, 10'h222, 1, 0);
      cyc(1, 1, 0, 0, 10'h0AA, 10'h155, 10'h3FF);
      chk_out("drain_back", 10'h0AA, 10'h155, 10'h3FF, 1, 0);
      cyc(0, 1, 0, 0, 10'h001, 10'h002, 10'h004);
      chk_out("drain2", 10'h001, 10'h002, 10'h004, 1, 0);
      cyc(0, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      chk_out("drain_blank", T00, T00, T00, 1, 0);

      // Frame end while draining: tokens, link drops, no frame_start
      cyc(0, 1, 0, 1, 10'h155, 10'h155, 10'h155);
      chk_out("drain_end", T10, T00, T00, 0, 0);
      cyc(0, 1, 0, 1, 10'h155, 10'h155, 10'h155);
      chk_out("off_again", T10, T00, T00, 0, 0);

      // Re-enable: 1 OFF + 4 HOLD cycles, then SYNC sees a rise
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      cyc(1, 0, 0, 1, 10'h0, 10'h0, 10'h0);
      chk_out("f2_start", T10, T00, T00, 1, 1);
`ifdef DVI_TX_LINK_STATS_EN
      chk("f2.fcnt", frame_cnt, 16'd2);
      chk("f2.derr", {15'd0, de_err}, 16'd0);
`endif
      cyc(1, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      cyc(1, 1, 0, 1, 10'h2AB, 10'h0F0, 10'h155);
      chk_out("f3_de", 10'h2AB, 10'h0F0, 10'h155, 1, 1);
`ifdef DVI_TX_LINK_STATS_EN
      chk("f3.fcnt", frame_cnt, 16'd3);
      chk("f3.derr", {15'd0, de_err}, 16'd1);
`endif
      cyc(1, 0, 0, 0, 10'h0, 10'h0, 10'h0);
      cyc(1, 0, 1, 1, 10'h0, 10'h0, 10'h0);
      chk_out("f4_start", T11, T00, T00, 1, 1);
`ifdef DVI_TX_LINK_STATS_EN
      chk("f4.fcnt", frame_cnt, 16'd4);
`endif
      cyc(1, 1, 0, 0, 10'h123, 10'h234, 10'h345);
      chk_out("f4_de", 10'h123, 10'h234, 10'h345, 1, 0);

      // Reset during RUN with active data
      rst = 1'b1;
      cyc(1, 1, 0, 0, 10'h123, 10'h234, 10'h345);
      chk_out("rst_run", T00, T00, T00, 0, 0);
`ifdef DVI_TX_LINK_STATS_EN
      chk("rst.fcnt", frame_cnt, 16'd0);
      chk("rst.derr", {15'd0, de_err}, 16'd0);
`endif
      rst = 1'b0;
      cyc(1, 1, 0, 1, 10'h123, 10'h234, 10'h345);
      chk_out("post_rst", T10, T00, T00, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
